// File: rtl/segment_collision_checker.sv
// Walks the Bresenham cell sequence between two grid cells, issuing one occupancy read per cell.
// Stops at the first occupied cell and returns a collide/clear verdict plus the number of reads.
module segment_collision_checker #(
    parameter int GRID_WIDTH_LOG2  = 8,
    parameter int GRID_HEIGHT_LOG2 = 8
) (
    input  logic                                      i_clk,
    input  logic                                      i_rst_n,
    input  logic                                      i_seg_vld,
    output logic                                      o_seg_rdy,
    input  logic [GRID_WIDTH_LOG2-1:0]                i_x0,
    input  logic [GRID_HEIGHT_LOG2-1:0]               i_y0,
    input  logic [GRID_WIDTH_LOG2-1:0]                i_x1,
    input  logic [GRID_HEIGHT_LOG2-1:0]               i_y1,
    output logic                                      o_res_vld,
    input  logic                                      i_res_rdy,
    output logic                                      o_collision,
    output logic [GRID_WIDTH_LOG2+GRID_HEIGHT_LOG2:0] o_cells_checked,
    output logic [GRID_WIDTH_LOG2-1:0]                o_grid_cell_x,
    output logic [GRID_HEIGHT_LOG2-1:0]               o_grid_cell_y,
    output logic                                      o_grid_vld,
    input  logic                                      i_grid_rdy,
    input  logic                                      i_grid_vld_out,
    input  logic                                      i_grid_r_occupied,
    output logic                                      o_grid_we,
    output logic                                      o_grid_w_occupied
);

    localparam int W  = GRID_WIDTH_LOG2;
    localparam int H  = GRID_HEIGHT_LOG2;
    localparam int AW = ((W > H) ? W : H) + 2;
    localparam int CW = W + H + 1;

    localparam logic [W-1:0]  X_ONE = 1;
    localparam logic [H-1:0]  Y_ONE = 1;
    localparam logic [CW-1:0] C_ONE = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_STEP,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [W-1:0]         r_cur_x;
    logic [H-1:0]         r_cur_y;
    logic [W-1:0]         r_end_x;
    logic [H-1:0]         r_end_y;
    logic signed [AW-1:0] r_dx;
    logic signed [AW-1:0] r_dy;
    logic signed [AW-1:0] r_err;
    logic                 r_sx_neg;
    logic                 r_sy_neg;
    logic                 r_collision;
    logic [CW-1:0]        r_cells;
    logic                 r_wait_first;

    logic                 w_accept;
    logic                 w_issue;
    logic                 w_rd_done;
    logic                 w_at_end;
    logic                 w_x_fwd;
    logic                 w_y_fwd;
    logic [W-1:0]         w_adx;
    logic [H-1:0]         w_ady;
    logic signed [AW-1:0] w_dx_init;
    logic signed [AW-1:0] w_dy_init;
    logic signed [AW:0]   w_e2;
    logic signed [AW:0]   w_dx_ext;
    logic signed [AW:0]   w_dy_ext;
    logic                 w_step_x;
    logic                 w_step_y;
    logic signed [AW-1:0] w_err_add_x;
    logic signed [AW-1:0] w_err_add_y;
    logic signed [AW-1:0] w_err_step;

    assign w_accept  = i_seg_vld && (r_state == S_IDLE);
    assign w_issue   = (r_state == S_ISSUE) && i_grid_rdy;
    // The grid clears vld_out on the cycle after accepting, so the first WAIT cycle is stale.
    assign w_rd_done = (r_state == S_WAIT) && !r_wait_first && i_grid_vld_out;
    assign w_at_end  = (r_cur_x == r_end_x) && (r_cur_y == r_end_y);

    assign w_x_fwd   = (i_x1 >= i_x0);
    assign w_y_fwd   = (i_y1 >= i_y0);
    assign w_adx     = w_x_fwd ? (i_x1 - i_x0) : (i_x0 - i_x1);
    assign w_ady     = w_y_fwd ? (i_y1 - i_y0) : (i_y0 - i_y1);
    assign w_dx_init = $signed({{(AW-W){1'b0}}, w_adx});
    assign w_dy_init = -$signed({{(AW-H){1'b0}}, w_ady});

    assign w_e2        = $signed({r_err, 1'b0});
    assign w_dx_ext    = $signed({r_dx[AW-1], r_dx});
    assign w_dy_ext    = $signed({r_dy[AW-1], r_dy});
    assign w_step_x    = (w_e2 >= w_dy_ext);
    assign w_step_y    = (w_e2 <= w_dx_ext);
    // Both adjustments are taken from the pre-step error so a diagonal move is a single cycle.
    assign w_err_add_x = w_step_x ? r_dy : '0;
    assign w_err_add_y = w_step_y ? r_dx : '0;
    assign w_err_step  = r_err + w_err_add_x + w_err_add_y;

    assign o_seg_rdy         = (r_state == S_IDLE);
    assign o_res_vld         = (r_state == S_DONE);
    assign o_collision       = r_collision;
    assign o_cells_checked   = r_cells;
    assign o_grid_cell_x     = r_cur_x;
    assign o_grid_cell_y     = r_cur_y;
    assign o_grid_vld        = w_issue;
    assign o_grid_we         = 1'b0;
    assign o_grid_w_occupied = 1'b0;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_ISSUE;
            S_ISSUE: if (i_grid_rdy) w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (w_rd_done) begin
                    if (i_grid_r_occupied || w_at_end) w_state_nxt = S_DONE;
                    else                               w_state_nxt = S_STEP;
                end
            end
            S_STEP:  w_state_nxt = S_ISSUE;
            S_DONE:  if (i_res_rdy) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cur_x      <= '0;
            r_cur_y      <= '0;
            r_end_x      <= '0;
            r_end_y      <= '0;
            r_dx         <= '0;
            r_dy         <= '0;
            r_err        <= '0;
            r_sx_neg     <= 1'b0;
            r_sy_neg     <= 1'b0;
            r_collision  <= 1'b0;
            r_cells      <= '0;
            r_wait_first <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cur_x     <= i_x0;
                        r_cur_y     <= i_y0;
                        r_end_x     <= i_x1;
                        r_end_y     <= i_y1;
                        r_dx        <= w_dx_init;
                        r_dy        <= w_dy_init;
                        r_err       <= w_dx_init + w_dy_init;
                        r_sx_neg    <= !w_x_fwd;
                        r_sy_neg    <= !w_y_fwd;
                        r_collision <= 1'b0;
                        r_cells     <= '0;
                    end
                end
                S_ISSUE: begin
                    if (i_grid_rdy) begin
                        r_cells      <= r_cells + C_ONE;
                        r_wait_first <= 1'b1;
                    end
                end
                S_WAIT: begin
                    r_wait_first <= 1'b0;
                    if (w_rd_done && i_grid_r_occupied) begin
                        r_collision <= 1'b1;
                    end
                end
                S_STEP: begin
                    r_err <= w_err_step;
                    if (w_step_x) r_cur_x <= r_sx_neg ? (r_cur_x - X_ONE) : (r_cur_x + X_ONE);
                    if (w_step_y) r_cur_y <= r_sy_neg ? (r_cur_y - Y_ONE) : (r_cur_y + Y_ONE);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_segment_collision_checker.sv
// Directed bench for segment_collision_checker against a behavioural occupancy grid
// (one-read-at-a-time, vld_out on the fourth cycle after accept, single programmable occupied cell).
module tb_segment_collision_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        seg_vld = 1'b0;
    logic        seg_rdy;
    logic [7:0]  x0 = '0, y0 = '0, x1 = '0, y1 = '0;
    logic        res_vld;
    logic        res_rdy = 1'b0;
    logic        collision;
    logic [16:0] cells_checked;
    logic [7:0]  grid_cell_x, grid_cell_y;
    logic        grid_vld;
    logic        grid_rdy;
    logic        grid_vld_out;
    logic        grid_r_occupied;
    logic        grid_we, grid_w_occupied;

    int errors = 0;
    int checks = 0;

    // Grid model state
    int   g_cnt;
    logic g_occ;
    logic occ_en = 1'b0;
    int   occ_x = 0, occ_y = 0;
    int   rd_x[$];
    int   rd_y[$];

    always #5 clk = ~clk;

    segment_collision_checker #(.GRID_WIDTH_LOG2(8), .GRID_HEIGHT_LOG2(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_seg_vld(seg_vld), .o_seg_rdy(seg_rdy),
        .i_x0(x0), .i_y0(y0), .i_x1(x1), .i_y1(y1),
        .o_res_vld(res_vld), .i_res_rdy(res_rdy),
        .o_collision(collision), .o_cells_checked(cells_checked),
        .o_grid_cell_x(grid_cell_x), .o_grid_cell_y(grid_cell_y),
        .o_grid_vld(grid_vld), .i_grid_rdy(grid_rdy),
        .i_grid_vld_out(grid_vld_out), .i_grid_r_occupied(grid_r_occupied),
        .o_grid_we(grid_we), .o_grid_w_occupied(grid_w_occupied)
    );

    assign grid_vld_out    = (g_cnt == 4);
    assign grid_r_occupied = g_occ;

    always @(posedge clk) begin
        if (!rst_n) begin
            g_cnt    <= 0;
            grid_rdy <= 1'b1;
            g_occ    <= 1'b0;
        end else if (grid_vld && grid_rdy) begin
            rd_x.push_back(int'(grid_cell_x));
            rd_y.push_back(int'(grid_cell_y));
            g_occ    <= occ_en && (int'(grid_cell_x) == occ_x) && (int'(grid_cell_y) == occ_y);
            grid_rdy <= 1'b0;
            g_cnt    <= 1;
        end else if (g_cnt == 4) begin
            g_cnt    <= 0;
            grid_rdy <= 1'b1;
        end else if (g_cnt != 0) begin
            g_cnt <= g_cnt + 1;
        end
    end

    task automatic run_seg(input int ax0, input int ay0, input int ax1, input int ay1,
                           output bit got_res);
        bit acc = 0;
        got_res = 0;
        rd_x.delete();
        rd_y.delete();
        x0 = 8'(ax0); y0 = 8'(ay0); x1 = 8'(ax1); y1 = 8'(ay1);
        seg_vld = 1'b1;
        for (int i = 0; i < 50 && !acc; i++) begin
            if (seg_rdy) acc = 1;
            @(posedge clk); #1;
        end
        seg_vld = 1'b0;
        if (acc) begin
            for (int i = 0; i < 3000 && !got_res; i++) begin
                if (res_vld) got_res = 1;
                else begin @(posedge clk); #1; end
            end
        end
    endtask

    task automatic accept_res();
        res_rdy = 1'b1;
        @(posedge clk); #1;
        res_rdy = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        checks++;
        if ({seg_rdy, res_vld, collision, cells_checked} !== {1'b1, 1'b0, 1'b0, 17'd0}) begin
            errors++;
            $display("FAIL reset_status got rdy=%b vld=%b col=%b cells=%0d want 1 0 0 0",
                     seg_rdy, res_vld, collision, cells_checked);
        end
        checks++;
        if ({grid_vld, grid_cell_x, grid_cell_y, grid_we, grid_w_occupied} !== 19'd0) begin
            errors++;
            $display("FAIL reset_grid got vld=%b x=%0d y=%0d we=%b wocc=%b want all 0",
                     grid_vld, grid_cell_x, grid_cell_y, grid_we, grid_w_occupied);
        end
    endtask

    task automatic test_horizontal();
        bit got;
        occ_en = 1'b0;
        run_seg(0, 0, 5, 0, got);
        checks++;
        if (got !== 1'b1) begin errors++; $display("FAIL horiz_res got timeout want res_vld"); end
        checks++;
        if ({collision, cells_checked} !== {1'b0, 17'd6}) begin
            errors++;
            $display("FAIL horiz_verdict got col=%b cells=%0d want col=0 cells=6", collision, cells_checked);
        end
        checks++;
        if (rd_x.size() !== 6) begin
            errors++;
            $display("FAIL horiz_nreads got %0d want 6", rd_x.size());
        end
        for (int i = 0; i < 6 && i < rd_x.size(); i++) begin
            checks++;
            if (rd_x[i] !== i || rd_y[i] !== 0) begin
                errors++;
                $display("FAIL horiz_read%0d got (%0d,%0d) want (%0d,0)", i, rd_x[i], rd_y[i], i);
            end
        end
        accept_res();
        checks++;
        if ({seg_rdy, res_vld} !== 2'b10) begin
            errors++;
            $display("FAIL horiz_release got rdy=%b vld=%b want 1 0", seg_rdy, res_vld);
        end
    endtask

    task automatic test_diagonal();
        bit got;
        occ_en = 1'b0;
        run_seg(0, 0, 3, 3, got);
        checks++;
        if (got !== 1'b1 || {collision, cells_checked} !== {1'b0, 17'd4}) begin
            errors++;
            $display("FAIL diag_verdict got res=%b col=%b cells=%0d want 1 0 4", got, collision, cells_checked);
        end
        checks++;
        if (rd_x.size() !== 4) begin errors++; $display("FAIL diag_nreads got %0d want 4", rd_x.size()); end
        for (int i = 0; i < 4 && i < rd_x.size(); i++) begin
            checks++;
            if (rd_x[i] !== i || rd_y[i] !== i) begin
                errors++;
                $display("FAIL diag_read%0d got (%0d,%0d) want (%0d,%0d)", i, rd_x[i], rd_y[i], i, i);
            end
        end
        accept_res();
    endtask

    task automatic test_collision();
        bit got;
        int ex[3] = '{0, 1, 2};
        int ey[3] = '{0, 1, 1};
        occ_en = 1'b1; occ_x = 2; occ_y = 1;
        run_seg(0, 0, 4, 2, got);
        checks++;
        if (got !== 1'b1 || {collision, cells_checked} !== {1'b1, 17'd3}) begin
            errors++;
            $display("FAIL coll_verdict got res=%b col=%b cells=%0d want 1 1 3", got, collision, cells_checked);
        end
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (rd_x.size() !== 3) begin errors++; $display("FAIL coll_nreads got %0d want 3", rd_x.size()); end
        for (int i = 0; i < 3 && i < rd_x.size(); i++) begin
            checks++;
            if (rd_x[i] !== ex[i] || rd_y[i] !== ey[i]) begin
                errors++;
                $display("FAIL coll_read%0d got (%0d,%0d) want (%0d,%0d)", i, rd_x[i], rd_y[i], ex[i], ey[i]);
            end
        end
        accept_res();
    endtask

    task automatic test_reverse();
        bit got;
        occ_en = 1'b1; occ_x = 4; occ_y = 9;
        run_seg(7, 9, 4, 9, got);
        checks++;
        if (got !== 1'b1 || {collision, cells_checked} !== {1'b1, 17'd4}) begin
            errors++;
            $display("FAIL rev_verdict got res=%b col=%b cells=%0d want 1 1 4", got, collision, cells_checked);
        end
        checks++;
        if (rd_x.size() !== 4) begin errors++; $display("FAIL rev_nreads got %0d want 4", rd_x.size()); end
        for (int i = 0; i < 4 && i < rd_x.size(); i++) begin
            checks++;
            if (rd_x[i] !== 7 - i || rd_y[i] !== 9) begin
                errors++;
                $display("FAIL rev_read%0d got (%0d,%0d) want (%0d,9)", i, rd_x[i], rd_y[i], 7 - i);
            end
        end
        accept_res();
    endtask

    task automatic test_degenerate_hold();
        bit got;
        occ_en = 1'b0;
        run_seg(10, 10, 10, 10, got);
        checks++;
        if (got !== 1'b1 || rd_x.size() !== 1 || cells_checked !== 17'd1) begin
            errors++;
            $display("FAIL degen_verdict got res=%b reads=%0d cells=%0d want 1 1 1", got, rd_x.size(), cells_checked);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({res_vld, seg_rdy, collision, cells_checked} !== {1'b1, 1'b0, 1'b0, 17'd1}) begin
                errors++;
                $display("FAIL degen_hold%0d got vld=%b rdy=%b col=%b cells=%0d want 1 0 0 1",
                         i, res_vld, seg_rdy, collision, cells_checked);
            end
        end
        accept_res();
    endtask

    task automatic test_reset_mid();
        bit got;
        int seen = 0;
        occ_en = 1'b0;
        rd_x.delete(); rd_y.delete();
        x0 = 8'd0; y0 = 8'd0; x1 = 8'd100; y1 = 8'd0;
        seg_vld = 1'b1;
        @(posedge clk); #1;
        seg_vld = 1'b0;
        for (int i = 0; i < 200 && seen < 3; i++) begin
            if (grid_vld) seen++;
            if (seen < 3) begin @(posedge clk); #1; end
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++;
        if ({seen == 3, seg_rdy, res_vld, grid_vld} !== 4'b1100) begin
            errors++;
            $display("FAIL rstmid_status got reads=%0d rdy=%b vld=%b gvld=%b want 3 1 0 0",
                     seen, seg_rdy, res_vld, grid_vld);
        end
        run_seg(0, 5, 2, 6, got);
        checks++;
        if (got !== 1'b1 || {collision, cells_checked} !== {1'b0, 17'd3} || rd_x.size() !== 3) begin
            errors++;
            $display("FAIL rstmid_fresh got res=%b col=%b cells=%0d reads=%0d want 1 0 3 3",
                     got, collision, cells_checked, rd_x.size());
        end
        checks++;
        if (rd_x.size() == 3 && (rd_x[1] !== 1 || rd_y[1] !== 6 || rd_x[2] !== 2 || rd_y[2] !== 6)) begin
            errors++;
            $display("FAIL rstmid_path got (%0d,%0d),(%0d,%0d) want (1,6),(2,6)", rd_x[1], rd_y[1], rd_x[2], rd_y[2]);
        end
        accept_res();
    endtask

    initial begin
        test_reset();
        test_horizontal();
        test_diagonal();
        test_collision();
        test_reverse();
        test_degenerate_hold();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/segment_collision_checker.md
Name: segment_collision_checker

Overview:
- Walks every grid cell on the straight segment between two cell coordinates using integer Bresenham stepping.
- Issues one occupancy read per cell to the occupancy grid block and stops at the first occupied cell.
- Returns a single collide/clear verdict for the segment, plus a cell count.
- Sits directly upstream of the occupancy grid in the RRT edge-validation path. The extend/steer logic feeds candidate edges into it.

Parameters:
- GRID_WIDTH_LOG2, 8, bits of cell x coordinate; must match the grid.
- GRID_HEIGHT_LOG2, 8, bits of cell y coordinate; must match the grid.

Ports:
- clk  in  1  memory clock, shared with occupancy grid
- rst_n  in  1  synchronous active-low reset
- seg_vld  in  1  segment request valid
- seg_rdy  out  1  checker can accept a segment
- x0  in  GRID_WIDTH_LOG2  start cell x
- y0  in  GRID_HEIGHT_LOG2  start cell y
- x1  in  GRID_WIDTH_LOG2  end cell x
- y1  in  GRID_HEIGHT_LOG2  end cell y
- res_vld  out  1  verdict valid
- res_rdy  in  1  consumer accepts verdict
- collision  out  1  1 = some cell on segment occupied
- cells_checked  out  GRID_WIDTH_LOG2+GRID_HEIGHT_LOG2+1  number of grid reads performed
- grid_cell_x  out  GRID_WIDTH_LOG2  to grid cell_x_in
- grid_cell_y  out  GRID_HEIGHT_LOG2  to grid cell_y_in
- grid_vld  out  1  to grid vld_in
- grid_rdy  in  1  from grid rdy
- grid_vld_out  in  1  from grid vld_out
- grid_r_occupied  in  1  from grid r_occupied
- grid_we  out  1  constant 0
- grid_w_occupied  out  1  constant 0

Behaviour:
- Clock and reset: single clock clk; synchronous active-low reset rst_n, sampled on posedge clk.
- Reset values: state=IDLE, seg_rdy=1, res_vld=0, collision=0, cells_checked=0, grid_vld=0, grid_cell_x/y=0. grid_we and grid_w_occupied are always 0.
- Reset mid-operation: aborts at the next edge. Any grid read in flight is ignored. The grid is reset on the same rst_n.
- Input handshake: a segment is accepted on a cycle with seg_vld && seg_rdy. seg_rdy=1 only in IDLE. All four coordinates are registered on accept.
- Registered values on accept:
  - cur=(x0,y0)
  - dx=|x1-x0|, dy=-|y1-y0|
  - sx=+1 if x1>=x0 else -1; sy likewise for y
  - err=dx+dy
  - cells_checked=0, collision=0
- Arithmetic: dx, dy and err are signed, width max(GRID_WIDTH_LOG2,GRID_HEIGHT_LOG2)+2. e2=2*err uses one further bit. No wrap is possible because cur stays within the bounding box of the endpoints.
- States and transitions:
  - IDLE: on accept -> ISSUE.
  - ISSUE:
    - Drive grid_cell_x/y=cur.
    - When grid_rdy=1: grid_vld=1 for exactly this one cycle, cells_checked+=1 -> WAIT.
    - Otherwise hold with grid_vld=0.
  - WAIT: grid_vld=0.
    - grid_vld_out is ignored in the first WAIT cycle (the grid clears it on accept).
    - From the second WAIT cycle on, when grid_vld_out=1, sample grid_r_occupied:
      - if 1: collision<=1 -> DONE.
      - else if cur==(x1,y1) -> DONE.
      - else -> STEP.
  - STEP (one cycle):
    - e2=2*err.
    - If e2>=dy: err+=dy, cur.x+=sx.
    - If e2<=dx: err+=dx, cur.y+=sy.
    - Both updates use the pre-step err and can occur in the same cycle (diagonal move).
    - -> ISSUE.
  - DONE: res_vld=1, collision and cells_checked held stable. On res_vld && res_rdy -> IDLE (res_vld=0, seg_rdy=1 next cycle).
- Latency per cell: ISSUE(1) + WAIT(4, matching the grid's START_READ->WAIT_READ->FINISH_READ->vld_out) + STEP(1), with grid_rdy returning 1 by the next ISSUE.
- No timeout: the checker waits in WAIT indefinitely.
- Degenerate segment (x0,y0)==(x1,y1): exactly one read, then DONE.
- Start and end cells are both checked.
- Early exit: no reads are issued after the first occupied cell.
- Write path: never writes the grid. Grid writes by other agents must be arbitrated outside this block.

Test Plan:
- Empty 256x256 grid, segment (0,0)->(5,0) -> res_vld with collision=0, cells_checked=6; grid reads at x=0..5, y=0 in order.
- Empty grid, (0,0)->(3,3) -> reads (0,0),(1,1),(2,2),(3,3); collision=0, cells_checked=4.
- Cell (2,1) occupied, (0,0)->(4,2) -> reads (0,0),(1,0)/(1,1) per Bresenham, then (2,1); collision=1 with no further reads.
- Reverse direction (7,9)->(4,9), cell (4,9) occupied -> 4 reads at x=7,6,5,4; collision=1, cells_checked=4.
- Degenerate segment (10,10)->(10,10) -> 1 read, cells_checked=1. Hold res_rdy=0 for 5 cycles -> res_vld, collision and cells_checked stable, seg_rdy=0 throughout.
- Assert rst_n=0 for 1 cycle while in WAIT on a long segment -> next cycle seg_rdy=1, res_vld=0, grid_vld=0. A fresh segment then completes correctly.
